player_bullet_pool: RTL and testbench



---
 rtl/player_bullet_pool_if.sv | 19 +
 rtl/player_bullet_pool.sv | 78 +++++++
 tb/tb_player_bullet_pool.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/player_bullet_pool_if.sv
// player_bullet_pool_if: player inputs, hit reports and bullet slot outputs of the bullet pool
interface player_bullet_pool_if;
   logic play;
   logic [7:0] keycode;
   logic [9:0] playerX, playerY, playerW;
   logic facing;
   logic [4:0] hit_clr;
   logic [9:0] bX, bY, b1X, b1Y, b2X, b2Y, b3X, b3Y, b4X, b4Y;
   logic [4:0] bActive;
   logic shot;
   modport master (
      output play, keycode, playerX, playerY, playerW, facing, hit_clr,
      input bX, bY, b1X, b1Y, b2X, b2Y, b3X, b3Y, b4X, b4Y, bActive, shot
   );
   modport slave (
      input play, keycode, playerX, playerY, playerW, facing, hit_clr,
      output bX, bY, b1X, b1Y, b2X, b2Y, b3X, b3Y, b4X, b4Y, bActive, shot
   );
endinterface

// File: rtl/player_bullet_pool.sv
// player_bullet_pool: five-slot player bullet launcher, mover and retirer, one step per frame
module player_bullet_pool #(
   parameter logic [7:0] FIRE_KEY = 8'h0D,
   parameter int SPEED = 4,
   parameter int COOLDOWN = 8,
   parameter int Y_OFS = 20,
   parameter int SCREEN_W = 640,
   parameter logic [9:0] PARK = 10'd1023
) (
   input logic frame_clk,
   input logic Reset,
   player_bullet_pool_if.slave io
);
   localparam int CW = $clog2(COOLDOWN + 1);
   typedef enum logic {IDLE, FLY} state_t;
   state_t st [5];
   logic [9:0] x [5];
   logic [9:0] y [5];
   logic [4:0] dir, act;
   logic [CW-1:0] cd;
   logic key_q, shot_q, press, launch;
   logic [2:0] sel;
   // descending scan so the lowest-index idle slot wins
   always_comb begin
      sel = 3'd0;
      act = '0;
      for (int i = 4; i >= 0; i--) begin
         act[i] = st[i] == FLY;
         if (st[i] == IDLE) sel = 3'(i);
      end
   end
   assign press = io.keycode == FIRE_KEY && !key_q;
   assign launch = press && cd == '0 && act != '1;
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         for (int i = 0; i < 5; i++) begin
            st[i] <= IDLE;
            x[i] <= PARK;
            y[i] <= PARK;
         end
         dir <= '0;
         cd <= '0;
         key_q <= 1'b0;
         shot_q <= 1'b0;
      end else if (io.play) begin
         key_q <= io.keycode == FIRE_KEY;
         shot_q <= launch;
         cd <= launch ? CW'(COOLDOWN) : (cd != '0 ? cd - CW'(1) : cd);
         for (int i = 0; i < 5; i++) begin
            if (st[i] == FLY) begin
               if (io.hit_clr[i] || (dir[i] && {1'b0, x[i]} + 11'(SPEED) >= 11'(SCREEN_W))
                   || (!dir[i] && x[i] < 10'(SPEED))) begin
                  st[i] <= IDLE;
                  x[i] <= PARK;
                  y[i] <= PARK;
               end else x[i] <= dir[i] ? x[i] + 10'(SPEED) : x[i] - 10'(SPEED);
            end else if (launch && sel == 3'(i)) begin
               st[i] <= FLY;
               x[i] <= io.facing ? io.playerX + io.playerW : io.playerX;
               y[i] <= io.playerY - 10'(Y_OFS);
               dir[i] <= io.facing;
            end
         end
      end else shot_q <= 1'b0;
   end
   assign io.bX = x[0];
   assign io.bY = y[0];
   assign io.b1X = x[1];
   assign io.b1Y = y[1];
   assign io.b2X = x[2];
   assign io.b2Y = y[2];
   assign io.b3X = x[3];
   assign io.b3Y = y[3];
   assign io.b4X = x[4];
   assign io.b4Y = y[4];
   assign io.bActive = act;
   assign io.shot = shot_q;
endmodule

// File: tb/tb_player_bullet_pool.sv
// tb_player_bullet_pool: directed vector table plus model-driven scoreboard for player_bullet_pool
module tb_player_bullet_pool;
   logic frame_clk = 1'b0;
   logic Reset = 1'b1;
   always #5 frame_clk = ~frame_clk;
   player_bullet_pool_if io();
   player_bullet_pool dut (.frame_clk(frame_clk), .Reset(Reset), .io(io.slave));
   localparam logic [7:0] K = 8'h0D;
   int checks = 0;
   int failures = 0;
   typedef struct {
      logic rst, play;
      logic [7:0] key;
      logic fac;
      logic [9:0] px, pw;
      logic [4:0] hit;
      int s;
      logic [4:0] act;
      logic shot;
      logic [9:0] ex, ey;
   } vec_t;
   typedef logic [105:0] snap_t;
   vec_t tbl[$];
   snap_t sbq[$];
   int mx[5], my[5], mcd;
   bit ma[5], md[5], mk, ms;

   function automatic vec_t v(input logic rst, play, input logic [7:0] key, input logic fac,
                              input logic [9:0] px, pw, input logic [4:0] hit, input int s,
                              input logic [4:0] act, input logic shot, input logic [9:0] ex, ey);
      vec_t r;
      r.rst = rst; r.play = play; r.key = key; r.fac = fac; r.px = px; r.pw = pw; r.hit = hit;
      r.s = s; r.act = act; r.shot = shot; r.ex = ex; r.ey = ey;
      return r;
   endfunction

   function automatic logic [19:0] pos(input int s);
      case (s)
         0: return {io.bX, io.bY};
         1: return {io.b1X, io.b1Y};
         2: return {io.b2X, io.b2Y};
         3: return {io.b3X, io.b3Y};
         default: return {io.b4X, io.b4Y};
      endcase
   endfunction

   function automatic snap_t dut_snap();
      return {io.bActive, io.shot, io.bX, io.bY, io.b1X, io.b1Y, io.b2X, io.b2Y,
              io.b3X, io.b3Y, io.b4X, io.b4Y};
   endfunction

   task automatic apply(input logic rst, play, input logic [7:0] key, input logic fac,
                        input logic [9:0] px, py, pw, input logic [4:0] hit);
      Reset = rst; io.play = play; io.keycode = key; io.facing = fac;
      io.playerX = px; io.playerY = py; io.playerW = pw; io.hit_clr = hit;
   endtask

   task automatic park(input int i);
      ma[i] = 0; mx[i] = 1023; my[i] = 1023;
   endtask

   // reference behaviour, stepped once per frame with the inputs being driven
   task automatic model(input bit r, p, input logic [7:0] k, input bit f,
                        input int px, py, pw, input logic [4:0] h);
      int fs;
      bit ln;
      snap_t e;
      if (r) begin
         for (int i = 0; i < 5; i++) park(i);
         mcd = 0; mk = 0; ms = 0;
      end else if (p) begin
         fs = -1;
         for (int i = 0; i < 5; i++) if (!ma[i] && fs < 0) fs = i;
         ln = (k == K) && !mk && mcd == 0 && fs >= 0;
         for (int i = 0; i < 5; i++) begin
            if (!ma[i]) continue;
            if (h[i]) park(i);
            else if (md[i]) begin
               if (mx[i] + 4 >= 640) park(i); else mx[i] += 4;
            end else begin
               if (mx[i] < 4) park(i); else mx[i] -= 4;
            end
         end
         if (ln) begin
            ma[fs] = 1; md[fs] = f;
            mx[fs] = f ? (px + pw) % 1024 : px;
            my[fs] = (py - 20 + 1024) % 1024;
         end
         mcd = ln ? 8 : (mcd > 0 ? mcd - 1 : 0);
         mk = k == K;
         ms = ln;
      end else ms = 0;
      for (int i = 0; i < 5; i++) begin
         e[101 + i] = ma[i];
         e[99 - 20 * i -: 10] = 10'(mx[i]);
         e[89 - 20 * i -: 10] = 10'(my[i]);
      end
      e[100] = ms;
      sbq.push_back(e);
   endtask

   task automatic sb_step(input bit r, p, input logic [7:0] k, input bit f,
                          input int px, py, pw, input logic [4:0] h, input int cyc);
      snap_t want, got;
      apply(r, p, k, f, 10'(px), 10'(py), 10'(pw), h);
      model(r, p, k, f, px, py, pw, h);
      @(posedge frame_clk);
      #1;
      checks++;
      got = dut_snap();
      if (sbq.size() == 0) begin
         failures++;
         $display("FAIL sb cyc=%0d scoreboard empty, got %h", cyc, got);
      end else begin
         want = sbq.pop_front();
         if (got !== want) begin
            failures++;
            $display("FAIL sb cyc=%0d got %h want %h", cyc, got, want);
         end
      end
   endtask

   initial begin
      apply(1, 0, 8'h00, 1, 10'd100, 10'd200, 10'd20, 5'd0);
      tbl.push_back(v(1, 0, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00000, 0, 1023, 1023));
      tbl.push_back(v(0, 1, K,     1, 100, 20, 5'd0,  0, 5'b00001, 1, 120, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 124, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 128, 180));
      tbl.push_back(v(0, 1, K,     1, 100, 20, 5'd0,  0, 5'b00001, 0, 132, 180));
      tbl.push_back(v(0, 1, K,     1, 100, 20, 5'd0,  0, 5'b00001, 0, 136, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 140, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 144, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 148, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 152, 180));
      tbl.push_back(v(0, 1, K,     1, 100, 20, 5'd0,  1, 5'b00011, 1, 120, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  1, 5'b00011, 0, 124, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd2,  1, 5'b00001, 0, 1023, 1023));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 168, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd2,  1, 5'b00001, 0, 1023, 1023));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 176, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 180, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 184, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 100, 20, 5'd0,  0, 5'b00001, 0, 188, 180));
      tbl.push_back(v(0, 1, K,     1, 100, 20, 5'd0,  1, 5'b00011, 1, 120, 180));
      tbl.push_back(v(0, 0, 8'h00, 1, 100, 20, 5'd0,  1, 5'b00011, 0, 120, 180));
      tbl.push_back(v(0, 0, K,     1, 100, 20, 5'd3,  0, 5'b00011, 0, 192, 180));
      tbl.push_back(v(0, 1, K,     1, 100, 20, 5'd0,  1, 5'b00011, 0, 124, 180));
      tbl.push_back(v(1, 1, 8'h00, 1, 100, 20, 5'd0,  1, 5'b00000, 0, 1023, 1023));
      tbl.push_back(v(0, 1, K,     1, 620, 12, 5'd0,  0, 5'b00001, 1, 632, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 620, 12, 5'd0,  0, 5'b00001, 0, 636, 180));
      tbl.push_back(v(0, 1, 8'h00, 1, 620, 12, 5'd0,  0, 5'b00000, 0, 1023, 1023));
      tbl.push_back(v(1, 1, 8'h00, 0, 6,   12, 5'd0,  0, 5'b00000, 0, 1023, 1023));
      tbl.push_back(v(0, 1, K,     0, 6,   12, 5'd0,  0, 5'b00001, 1, 6, 180));
      tbl.push_back(v(0, 1, 8'h00, 0, 6,   12, 5'd0,  0, 5'b00001, 0, 2, 180));
      tbl.push_back(v(0, 1, 8'h00, 0, 6,   12, 5'd0,  0, 5'b00000, 0, 1023, 1023));
      for (int n = 0; n < tbl.size(); n++) begin
         apply(tbl[n].rst, tbl[n].play, tbl[n].key, tbl[n].fac, tbl[n].px, 10'd200, tbl[n].pw, tbl[n].hit);
         @(posedge frame_clk);
         #1;
         checks++;
         if (io.bActive !== tbl[n].act || io.shot !== tbl[n].shot || pos(tbl[n].s) !== {tbl[n].ex, tbl[n].ey}) begin
            failures++;
            $display("FAIL tbl[%0d] got act=%b shot=%b pos=%0d,%0d want act=%b shot=%b pos=%0d,%0d", n,
                     io.bActive, io.shot, pos(tbl[n].s) >> 10, pos(tbl[n].s) & 20'h3FF,
                     tbl[n].act, tbl[n].shot, tbl[n].ex, tbl[n].ey);
         end
      end
      // fill all five slots, then show blocked presses leave the cooldown at zero
      sb_step(1, 0, 8'h00, 1, 100, 200, 20, 5'd0, 0);
      for (int k = 0; k < 5; k++) begin
         sb_step(0, 1, K, 1, 100, 200, 20, 5'd0, 1 + 9 * k);
         for (int j = 0; j < 8; j++) sb_step(0, 1, 8'h00, 1, 100, 200, 20, 5'd0, 2 + 9 * k + j);
      end
      sb_step(0, 1, K, 1, 100, 200, 20, 5'd0, 50);
      sb_step(0, 1, 8'h00, 1, 100, 200, 20, 5'd0, 51);
      sb_step(0, 1, K, 1, 100, 200, 20, 5'd0, 52);
      sb_step(0, 1, 8'h00, 1, 100, 200, 20, 5'b00100, 53);
      sb_step(0, 1, K, 1, 300, 100, 20, 5'd0, 54);
      sb_step(0, 1, 8'h00, 1, 300, 100, 20, 5'd0, 55);
      for (int c = 0; c < 400; c++)
         sb_step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) == 0 ? K : 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 639), $urandom_range(20, 479),
                 $urandom_range(0, 31),
                 $urandom_range(0, 7) == 0 ? 5'(1 << $urandom_range(0, 4)) : 5'd0, 100 + c);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
